pwm_dac_output: RTL and testbench

PWM_DAC_OUTPUT -- requirements
Module: pwm_dac_output

---
 rtl/pwm_dac_output.sv | 113 +++++++++++
 tb/tb_pwm_dac_output.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dac_output.sv
// PWM DAC output stage: scales an 8-bit wave sample, latches it as a per-frame
// duty value and emits a 255-tick PWM stream with a soft-start duty ramp.
module pwm_dac_output #(
  parameter int TICK_DIV  = 1,
  parameter int RAMP_STEP = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample_in,
  input  logic [1:0] amp_select,
  input  logic       enable,
  output logic       pwm_out,
  output logic       frame_start,
  output logic       active,
  output logic [7:0] duty_q
);

  typedef enum logic [1:0] {IDLE, RAMP, RUN, DRAIN} state_t;

  localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);
  localparam logic [7:0] STEP     = 8'(RAMP_STEP);

  state_t     state, state_next;
  logic [7:0] div_cnt, pwm_cnt, ramp_level;
  logic [7:0] scaled, ramp_sat, duty_next, ramp_next;
  logic [8:0] ramp_sum;
  logic       tick_en, frame_end, load;

  assign active    = (state != IDLE);
  assign tick_en   = active && (div_cnt == DIV_LAST);
  assign frame_end = tick_en && (pwm_cnt == 8'd254);
  assign pwm_out   = active && (pwm_cnt < duty_q);

  always_comb begin
    case (amp_select)
      2'b00:   scaled = sample_in;
      2'b01:   scaled = (sample_in >> 1) + (sample_in >> 2);
      2'b10:   scaled = sample_in >> 1;
      default: scaled = sample_in >> 2;
    endcase
  end

  // Soft-start limit saturates at full scale instead of wrapping.
  assign ramp_sum = {1'b0, ramp_level} + {1'b0, STEP};
  assign ramp_sat = ramp_sum[8] ? 8'hFF : ramp_sum[7:0];

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    duty_next  = duty_q;
    ramp_next  = ramp_level;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = RAMP;
          ramp_next  = STEP;
          duty_next  = (scaled < STEP) ? scaled : STEP;
          load       = 1'b1;
        end
      end
      RAMP: begin
        if (frame_end) begin
          ramp_next = ramp_sat;
          duty_next = (scaled < ramp_sat) ? scaled : ramp_sat;
          load      = 1'b1;
          if (!enable)              state_next = DRAIN;
          else if (ramp_sat == 8'hFF) state_next = RUN;
        end else if (!enable) begin
          state_next = DRAIN;
        end
      end
      RUN: begin
        if (frame_end) begin
          duty_next = scaled;
          load      = 1'b1;
        end
        if (!enable) state_next = DRAIN;
      end
      DRAIN: begin
        if (frame_end) begin
          state_next = IDLE;
          duty_next  = 8'd0;
          ramp_next  = 8'd0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      div_cnt     <= 8'd0;
      pwm_cnt     <= 8'd0;
      ramp_level  <= 8'd0;
      duty_q      <= 8'd0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_next;
      duty_q      <= duty_next;
      ramp_level  <= ramp_next;
      frame_start <= load;
      if (!active || tick_en) div_cnt <= 8'd0;
      else                    div_cnt <= div_cnt + 8'd1;
      if (!active)            pwm_cnt <= 8'd0;
      else if (frame_end)     pwm_cnt <= 8'd0;
      else if (tick_en)       pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pwm_dac_output.sv
// Directed bench for pwm_dac_output: soft-start ramp, scaling table, frame latch,
// drain, mid-frame reset and a slow-tick instance.
module tb_pwm_dac_output;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sample_in;
  logic [1:0] amp_select;
  logic       enable;
  logic       pwm_out, frame_start, active;
  logic [7:0] duty_q;
  logic       pwm_out4, frame_start4, active4;
  logic [7:0] duty_q4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pwm_dac_output #(.TICK_DIV(1), .RAMP_STEP(64)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .amp_select(amp_select),
    .enable(enable), .pwm_out(pwm_out), .frame_start(frame_start),
    .active(active), .duty_q(duty_q)
  );

  pwm_dac_output #(.TICK_DIV(4), .RAMP_STEP(64)) dut4 (
    .clk(clk), .reset(reset), .sample_in(sample_in), .amp_select(amp_select),
    .enable(enable), .pwm_out(pwm_out4), .frame_start(frame_start4),
    .active(active4), .duty_q(duty_q4)
  );

  typedef struct {
    logic [7:0] sample;
    logic [1:0] amp;
    int         duty;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Advances to the next cycle with frame_start high; n = cycles advanced.
  task automatic wait_fs(output int n);
    int found;
    found = 0;
    n = 0;
    while (!found && n < 2000) begin
      @(negedge clk);
      n++;
      if (frame_start) found = 1;
    end
    check("frame_start_seen", found, 1);
  endtask

  initial begin
    int n, hi, fsx, first_low;
    int ramp_exp[3] = '{128, 192, 200};

    vecs[0] = '{8'd255, 2'b00, 255};
    vecs[1] = '{8'd0,   2'b00, 0};
    vecs[2] = '{8'd200, 2'b01, 150};
    vecs[3] = '{8'd200, 2'b10, 100};
    vecs[4] = '{8'd200, 2'b11, 50};
    vecs[5] = '{8'd37,  2'b01, 27};
    vecs[6] = '{8'd3,   2'b11, 0};
    vecs[7] = '{8'd100, 2'b00, 100};

    reset = 1'b1; enable = 1'b0; sample_in = 8'd200; amp_select = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_active", active, 0);
    check("rst_pwm", pwm_out, 0);
    check("rst_fs", frame_start, 0);
    check("rst_duty", duty_q, 0);

    // Soft-start ramp 64,128,192 then RUN at 200; enable honoured at first edge.
    reset = 1'b0; enable = 1'b1;
    @(negedge clk);
    check("start_fs", frame_start, 1);
    check("start_active", active, 1);
    check("start_duty", duty_q, 64);
    check("start_pwm", pwm_out, 1);
    for (int k = 0; k < 3; k++) begin
      wait_fs(n);
      check("ramp_frame_len", n, 255);
      check("ramp_duty", duty_q, ramp_exp[k]);
    end

    // Scaling table applied in RUN, one vector per frame.
    for (int i = 0; i < 8; i++) begin
      sample_in = vecs[i].sample; amp_select = vecs[i].amp;
      wait_fs(n);
      check("vec_duty", duty_q, vecs[i].duty);
      hi = 0; fsx = 0;
      for (int j = 0; j < 255; j++) begin
        if (j > 0) begin
          @(negedge clk);
          fsx += int'(frame_start);
        end
        hi += int'(pwm_out);
      end
      check("vec_high_time", hi, vecs[i].duty);
      check("vec_fs_single", fsx, 0);
    end

    // Mid-frame sample change is deferred to the next frame.
    wait_fs(n);
    check("hold_duty_start", duty_q, 100);
    hi = int'(pwm_out);
    for (int j = 1; j < 255; j++) begin
      @(negedge clk);
      if (j == 50) sample_in = 8'd20;
      hi += int'(pwm_out);
    end
    check("hold_duty_end", duty_q, 100);
    check("hold_high_time", hi, 100);
    wait_fs(n);
    check("hold_new_duty", duty_q, 20);

    // Drop enable at pwm_cnt=10; re-assert during DRAIN is ignored.
    hi = int'(pwm_out); fsx = 0;
    for (int j = 1; j < 255; j++) begin
      @(negedge clk);
      if (j == 10) enable = 1'b0;
      if (j == 15) enable = 1'b1;
      if (j == 100) check("drain_active", active, 1);
      hi += int'(pwm_out);
      fsx += int'(frame_start);
    end
    check("drain_duty", duty_q, 20);
    check("drain_high_time", hi, 20);
    check("drain_no_fs", fsx, 0);
    @(negedge clk);
    check("idle_active", active, 0);
    check("idle_pwm", pwm_out, 0);
    check("idle_fs", frame_start, 0);
    check("idle_duty", duty_q, 0);
    @(negedge clk);
    check("restart_fs", frame_start, 1);
    check("restart_active", active, 1);
    check("restart_duty", duty_q, 20);

    // Reset mid-RAMP at pwm_cnt=120, then restart from RAMP_STEP.
    repeat (120) @(negedge clk);
    reset = 1'b1; sample_in = 8'd200;
    @(negedge clk);
    check("mrst_active", active, 0);
    check("mrst_pwm", pwm_out, 0);
    check("mrst_fs", frame_start, 0);
    check("mrst_duty", duty_q, 0);
    reset = 1'b0;
    @(negedge clk);
    check("mrst_restart_fs", frame_start, 1);
    check("mrst_restart_duty", duty_q, 64);

    // enable low coincident with frame end: latch, then run that frame fully.
    repeat (254) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("coinc_fs", frame_start, 1);
    check("coinc_duty", duty_q, 128);
    hi = int'(pwm_out);
    for (int j = 1; j < 255; j++) begin
      @(negedge clk);
      hi += int'(pwm_out);
    end
    check("coinc_active_end", active, 1);
    check("coinc_high_time", hi, 128);
    @(negedge clk);
    check("coinc_idle", active, 0);
    check("coinc_idle_fs", frame_start, 0);

    // TICK_DIV=4 instance: 1020-clock frame, pwm_cnt steps every 4th clock.
    reset = 1'b1; enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0; enable = 1'b1; sample_in = 8'd200; amp_select = 2'b00;
    @(negedge clk);
    check("div4_fs", frame_start4, 1);
    check("div4_duty", duty_q4, 64);
    n = 0; hi = int'(pwm_out4); first_low = -1;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (frame_start4) break;
      if (!pwm_out4 && first_low < 0) first_low = n;
      hi += int'(pwm_out4);
    end
    check("div4_frame_len", n, 1020);
    check("div4_high_time", hi, 256);
    check("div4_first_low", first_low, 256);
    check("div4_next_duty", duty_q4, 128);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
